alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter WIDTH, default 4, datapath and register width in bits (legal range 4..16).
REQ-002 Parameter NREGS, default 4, number of general registers (power of two, 2..16); RW = log2(NREGS).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  instruction present this cycle.
REQ-006 in_ready  output  1  unit can accept an instruction this cycle.
REQ-007 op  input  4  opcode (see REQ-014).
REQ-008 dst, src_a, src_b  input  RW each  destination and source register indices.
REQ-009 imm  input  WIDTH  immediate for LDI.
REQ-010 out_valid  output  1  one-cycle completion pulse.
REQ-011 result  output  WIDTH  result of the completed instruction; held until next completion.
REQ-012 carry, ovf, zero, illegal  output  1 each  flags of the completed instruction; held until next completion.
REQ-013 dbg_sel  input  RW / dbg_data  output  WIDTH  combinational register read port for the display path.

Function
REQ-014 Opcodes: 0 ADD a+b, 1 SUB a-b, 2 AND, 3 OR, 4 XOR, 5 NOT a, 6 SHL a by 1, 7 SHR a logical by 1, 8 MUL unsigned a*b, 9 LDI dst=imm; 10..15 illegal.
REQ-015 a = reg[src_a], b = reg[src_b], sampled at acceptance.
REQ-016 Acceptance = in_valid && in_ready at a rising edge; in_ready high only in IDLE.
REQ-017 States: IDLE, EXEC, MUL; IDLE->EXEC on accepted non-MUL op, IDLE->MUL on accepted MUL, EXEC->IDLE after 1 cycle, MUL->IDLE after WIDTH iteration cycles.
REQ-018 Latency: non-MUL out_valid on cycle after acceptance; MUL out_valid WIDTH+1 cycles after acceptance.
REQ-019 MUL implemented as iterative shift-add, one partial-product bit per cycle, 2*WIDTH-bit accumulator; no combinational multiplier.
REQ-020 out_valid asserts exactly one cycle per accepted instruction; no backpressure on output.
REQ-021 reg[dst] written on the same edge that raises out_valid; illegal ops write nothing.
REQ-022 in_ready high in the out_valid cycle; an instruction accepted then reads the just-written value.
REQ-023 ADD: carry = carry-out, ovf = signed overflow. SUB: carry = borrow (a<b unsigned), ovf = signed overflow.
REQ-024 AND/OR/XOR/NOT/LDI: carry=0, ovf=0. SHL: carry = a[WIDTH-1]; SHR: carry = a[0]; ovf=0.
REQ-025 MUL: result = low WIDTH bits, ovf = 1 if high WIDTH bits nonzero, carry=0.
REQ-026 zero = (result == 0) for all legal ops; illegal: result=0, zero=0, carry=0, ovf=0, illegal=1.
REQ-027 in_valid while in_ready=0 is ignored (not queued); source must hold until accepted.
REQ-028 dst equal to a source index is legal; sources use pre-write values.

Reset
REQ-029 rst_n low: state=IDLE, all registers=0, out_valid=0, result=0, all flags=0, in_ready=1 after release; MUL in flight aborted, no write, no out_valid.
REQ-030 First acceptance possible on first rising edge with rst_n high.

Verification (WIDTH=4, NREGS=4)
REQ-031 LDI r0=7, LDI r1=1, ADD r2=r0+r1 -> result=8, ovf=1, carry=0, zero=0, out_valid 1 cycle after accept.
REQ-032 LDI r0=3, r1=5, SUB r2=r0-r1 -> result=0xE, carry=1, ovf=0; SUB r3=r1-r1 -> result=0, zero=1.
REQ-033 MUL 5*3 -> result=0xF, ovf=0, out_valid exactly 5 cycles after accept, in_ready=0 for 4 cycles; MUL 6*3 -> result=2, ovf=1.
REQ-034 Opcode 0xF -> illegal=1, result=0, dbg_data of dst unchanged.
REQ-035 rst_n low during cycle 2 of MUL -> no out_valid, dbg_data of all regs=0, in_ready=1 after release.
REQ-036 Back-to-back: ADD r1=r0+r0 accepted in out_valid cycle of LDI r0=2 -> result=4.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execution unit with a small register file and an iterative
// shift-add multiplier; one instruction in flight, results held until the next completion.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREGS = 4,
  localparam int unsigned RW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [RW-1:0]    dst,
  input  logic [RW-1:0]    src_a,
  input  logic [RW-1:0]    src_b,
  input  logic [WIDTH-1:0] imm,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             illegal,
  input  logic [RW-1:0]    dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_t;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3, OP_XOR = 4'd4,
    OP_NOT = 4'd5, OP_SHL = 4'd6, OP_SHR = 4'd7, OP_MUL = 4'd8, OP_LDI = 4'd9
  } opcode_t;

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(WIDTH);

  state_t             state;
  logic [WIDTH-1:0]   regs [NREGS];
  opcode_t            op_q;
  logic [RW-1:0]      dst_q;
  logic [WIDTH-1:0]   a_q, b_q, imm_q;
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   ex_res;
  logic               ex_c, ex_v, ex_ill;

  assign in_ready = (state == S_IDLE);
  assign dbg_data = regs[dbg_sel];

  always_comb begin
    sum    = '0;
    ex_res = '0;
    ex_c   = 1'b0;
    ex_v   = 1'b0;
    ex_ill = 1'b0;
    case (op_q)
      OP_ADD: begin
        sum    = {1'b0, a_q} + {1'b0, b_q};
        ex_res = sum[WIDTH-1:0];
        ex_c   = sum[WIDTH];
        ex_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (ex_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        ex_res = a_q - b_q;
        ex_c   = (a_q < b_q);
        ex_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (ex_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: ex_res = a_q & b_q;
      OP_OR:  ex_res = a_q | b_q;
      OP_XOR: ex_res = a_q ^ b_q;
      OP_NOT: ex_res = ~a_q;
      OP_SHL: begin
        ex_res = {a_q[WIDTH-2:0], 1'b0};
        ex_c   = a_q[WIDTH-1];
      end
      OP_SHR: begin
        ex_res = {1'b0, a_q[WIDTH-1:1]};
        ex_c   = a_q[0];
      end
      OP_LDI: ex_res = imm_q;
      default: ex_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      regs      <= '{default: '0};
      op_q      <= OP_ADD;
      dst_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q  <= opcode_t'(op);
            dst_q <= dst;
            a_q   <= regs[src_a];
            b_q   <= regs[src_b];
            imm_q <= imm;
            if (op == OP_MUL) begin
              state  <= S_MUL;
              acc    <= '0;
              mcand  <= {{WIDTH{1'b0}}, regs[src_a]};
              mplier <= regs[src_b];
              cnt    <= '0;
            end else begin
              state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          state     <= S_IDLE;
          out_valid <= 1'b1;
          result    <= ex_res;
          carry     <= ex_c;
          ovf       <= ex_v;
          zero      <= !ex_ill && (ex_res == '0);
          illegal   <= ex_ill;
          if (!ex_ill) regs[dst_q] <= ex_res;
        end
        S_MUL: begin
          // WIDTH add/shift steps, then one retire cycle reading the settled accumulator
          if (cnt == CNT_DONE) begin
            state       <= S_IDLE;
            out_valid   <= 1'b1;
            result      <= acc[WIDTH-1:0];
            carry       <= 1'b0;
            ovf         <= |acc[2*WIDTH-1:WIDTH];
            zero        <= (acc[WIDTH-1:0] == '0);
            illegal     <= 1'b0;
            regs[dst_q] <= acc[WIDTH-1:0];
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit (WIDTH=4, NREGS=4) with hand-computed expectations.
module tb_alu_exec_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op;
  logic [1:0] dst, src_a, src_b;
  logic [3:0] imm;
  logic       out_valid;
  logic [3:0] result;
  logic       carry, ovf, zero, illegal;
  logic [1:0] dbg_sel;
  logic [3:0] dbg_data;

  int vectors = 0;
  int miscompares = 0;
  int lat, busy, ov_seen;

  alu_exec_unit #(.WIDTH(4), .NREGS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .dst(dst), .src_a(src_a), .src_b(src_b), .imm(imm),
    .out_valid(out_valid), .result(result),
    .carry(carry), .ovf(ovf), .zero(zero), .illegal(illegal),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present at a falling edge; accepted on the following rising edge.
  task automatic issue(input logic [3:0] o, input logic [1:0] d, input logic [1:0] sa,
                       input logic [1:0] sb, input logic [3:0] im);
    @(negedge clk);
    chk("in_ready_before_issue", {15'd0, in_ready}, 16'd1);
    op = o; dst = d; src_a = sa; src_b = sb; imm = im; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(output int l, output int b);
    l = 0; b = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        l = k;
        break;
      end
      if (!in_ready) b++;
    end
  endtask

  task automatic run(input string tag, input logic [3:0] o, input logic [1:0] d,
                     input logic [1:0] sa, input logic [1:0] sb, input logic [3:0] im,
                     input int exp_lat, input int exp_busy,
                     input logic [3:0] r, input logic c, input logic v,
                     input logic z, input logic il);
    issue(o, d, sa, sb, im);
    wait_done(lat, busy);
    chk({tag, "_latency"}, 16'(lat), 16'(exp_lat));
    chk({tag, "_busy"}, 16'(busy), 16'(exp_busy));
    chk({tag, "_in_ready"}, {15'd0, in_ready}, 16'd1);
    chk({tag, "_result"}, {12'd0, result}, {12'd0, r});
    chk({tag, "_flags"}, {12'd0, carry, ovf, zero, illegal}, {12'd0, c, v, z, il});
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] idx, input logic [3:0] exp);
    dbg_sel = idx;
    #1;
    chk(tag, {12'd0, dbg_data}, {12'd0, exp});
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = '0; dst = '0; src_a = '0; src_b = '0;
    imm = '0; dbg_sel = '0;
    #1;
    chk("reset_out_valid", {15'd0, out_valid}, 16'd0);
    chk("reset_result", {12'd0, result}, 16'd0);
    chk("reset_flags", {12'd0, carry, ovf, zero, illegal}, 16'd0);
    for (int i = 0; i < 4; i++) chk_reg("reset_reg", 2'(i), 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("reset_in_ready", {15'd0, in_ready}, 16'd1);

    // ADD with signed overflow: 7 + 1
    run("ldi_r0_7", 4'd9, 2'd0, 2'd0, 2'd0, 4'h7, 1, 0, 4'h7, 0, 0, 0, 0);
    run("ldi_r1_1", 4'd9, 2'd1, 2'd0, 2'd0, 4'h1, 1, 0, 4'h1, 0, 0, 0, 0);
    run("add_7_1",  4'd0, 2'd2, 2'd0, 2'd1, 4'h0, 1, 0, 4'h8, 0, 1, 0, 0);
    chk_reg("add_7_1_r2", 2'd2, 4'h8);

    // SUB with borrow and zero result
    run("ldi_r0_3", 4'd9, 2'd0, 2'd0, 2'd0, 4'h3, 1, 0, 4'h3, 0, 0, 0, 0);
    run("ldi_r1_5", 4'd9, 2'd1, 2'd0, 2'd0, 4'h5, 1, 0, 4'h5, 0, 0, 0, 0);
    run("sub_3_5",  4'd1, 2'd2, 2'd0, 2'd1, 4'h0, 1, 0, 4'hE, 1, 0, 0, 0);
    run("sub_5_5",  4'd1, 2'd3, 2'd1, 2'd1, 4'h0, 1, 0, 4'h0, 0, 0, 1, 0);

    // Logic and shift ops on r0=0011, r1=0101
    run("and", 4'd2, 2'd2, 2'd0, 2'd1, 4'h0, 1, 0, 4'h1, 0, 0, 0, 0);
    run("or",  4'd3, 2'd2, 2'd0, 2'd1, 4'h0, 1, 0, 4'h7, 0, 0, 0, 0);
    run("xor", 4'd4, 2'd2, 2'd0, 2'd1, 4'h0, 1, 0, 4'h6, 0, 0, 0, 0);
    run("not", 4'd5, 2'd2, 2'd0, 2'd0, 4'h0, 1, 0, 4'hC, 0, 0, 0, 0);
    run("shl", 4'd6, 2'd2, 2'd1, 2'd0, 4'h0, 1, 0, 4'hA, 0, 0, 0, 0);
    run("shr", 4'd7, 2'd2, 2'd1, 2'd0, 4'h0, 1, 0, 4'h2, 1, 0, 0, 0);

    // Unsigned carry-out without signed overflow: -1 + 5
    run("ldi_r2_f", 4'd9, 2'd2, 2'd0, 2'd0, 4'hF, 1, 0, 4'hF, 0, 0, 0, 0);
    run("add_f_5",  4'd0, 2'd3, 2'd2, 2'd1, 4'h0, 1, 0, 4'h4, 1, 0, 0, 0);

    // Multiplies: latency WIDTH+1 edges, in_ready low throughout
    run("mul_5x3", 4'd8, 2'd2, 2'd1, 2'd0, 4'h0, 5, 4, 4'hF, 0, 0, 0, 0);
    chk_reg("mul_5x3_r2", 2'd2, 4'hF);
    run("ldi_r0_6", 4'd9, 2'd0, 2'd0, 2'd0, 4'h6, 1, 0, 4'h6, 0, 0, 0, 0);
    run("ldi_r1_3", 4'd9, 2'd1, 2'd0, 2'd0, 4'h3, 1, 0, 4'h3, 0, 0, 0, 0);
    run("mul_6x3",  4'd8, 2'd3, 2'd0, 2'd1, 4'h0, 5, 0 + 4, 4'h2, 0, 1, 0, 0);
    chk_reg("mul_6x3_r3", 2'd3, 4'h2);

    // Illegal opcode writes nothing; out_valid is a single pulse
    run("illegal_f", 4'hF, 2'd3, 2'd0, 2'd1, 4'h9, 1, 0, 4'h0, 0, 0, 0, 1);
    chk_reg("illegal_r3_kept", 2'd3, 4'h2);
    @(posedge clk); #1;
    chk("out_valid_pulse", {15'd0, out_valid}, 16'd0);

    // Back-to-back: ADD accepted in the out_valid cycle of LDI sees the new r0
    run("ldi_r0_2", 4'd9, 2'd0, 2'd0, 2'd0, 4'h2, 1, 0, 4'h2, 0, 0, 0, 0);
    chk("b2b_in_ready", {15'd0, in_ready}, 16'd1);
    op = 4'd0; dst = 2'd1; src_a = 2'd0; src_b = 2'd0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_done(lat, busy);
    chk("b2b_latency", 16'(lat), 16'd1);
    chk("b2b_result", {12'd0, result}, 16'h4);
    chk_reg("b2b_r1", 2'd1, 4'h4);

    // In-place update: r0 = r0 + r0 reads the old r0
    run("add_inplace", 4'd0, 2'd0, 2'd0, 2'd0, 4'h0, 1, 0, 4'h4, 0, 0, 0, 0);

    // Reset during the second cycle of a MUL aborts it completely
    issue(4'd8, 2'd2, 2'd0, 2'd1, 4'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid_in_reset", {15'd0, out_valid}, 16'd0);
    chk("abort_result_in_reset", {12'd0, result}, 16'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("abort_in_ready", {15'd0, in_ready}, 16'd1);
    ov_seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (out_valid) ov_seen++;
    end
    chk("abort_no_out_valid", 16'(ov_seen), 16'd0);
    for (int i = 0; i < 4; i++) chk_reg("abort_reg_cleared", 2'(i), 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
